addr_step_seq: RTL and testbench
================================

ADDR_STEP_SEQ -- requirements
Module: addr_step_seq

Interface
REQ-001 The block SHALL have parameter CNT_W, default `Data_Addr_width, the width of segment-length and step counters.
REQ-002 The block SHALL have parameter WIN_W, default 7, the width of the window-length input.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: one-cycle request to sequence one segment; sampled only in IDLE.
REQ-006 The block SHALL have port segLen, input, CNT_W bits: steps per parallel segment, captured on accepted start.
REQ-007 The block SHALL have port winLen, input, WIN_W bits: sliding-window length, captured on accepted start; 0 treated as 1.
REQ-008 The block SHALL have port hold, input, 1 bit: stall; freezes stepping while high.
REQ-009 The block SHALL have port Init_flag, output, 1 bit: load initial Rf/Qf/Rg/Qg into the address-step stage.
REQ-010 The block SHALL have port CmpDirection, output, 1 bit: 1 means forward step, 0 means backward step.
REQ-011 The block SHALL have port Step_en, output, 1 bit: a valid address step occurs this cycle.
REQ-012 The block SHALL have port Win_idx, output, CNT_W bits: index of the current window, starting at 0.
REQ-013 The block SHALL have port Step_cnt, output, WIN_W bits: step index within the current pass.
REQ-014 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of the segment.

Function
REQ-016 The FSM SHALL have states IDLE, INIT, FWD, BWD, DONE.
REQ-017 In IDLE, start=1 SHALL capture segLen and winLen and set remaining=segLen; the next state SHALL be INIT, or DONE if segLen=0.
REQ-018 INIT SHALL assert Init_flag=1 with Step_en=0 and CmpDirection=1; n=min(winLen,remaining) SHALL be latched; the next state SHALL be FWD unless hold=1, in which case the FSM SHALL stay in INIT.
REQ-019 FWD SHALL assert CmpDirection=1 and Step_en=!hold; Step_cnt SHALL increment per unstalled cycle from 0 to n-1; after step n-1 the next state SHALL be BWD.
REQ-020 BWD SHALL assert CmpDirection=0 and Step_en=!hold; Step_cnt SHALL run n-1 down to 0; after step 0, remaining SHALL become remaining-n.
REQ-021 At the end of BWD, the next state SHALL be INIT with Win_idx+1 if remaining>0, otherwise DONE.
REQ-022 DONE SHALL pulse done=1 for one cycle, then return to IDLE.
REQ-023 When hold=1, Step_cnt, remaining and state SHALL be frozen; CmpDirection SHALL keep its value.
REQ-024 start SHALL be ignored while busy=1.
REQ-025 A last window shorter than winLen SHALL use n=remaining; subtraction SHALL never underflow.
REQ-026 Outputs SHALL be registered, and the Init_flag-to-first-FWD latency SHALL be exactly 1 cycle when hold=0.

Reset
REQ-027 While reset=0 the FSM SHALL be in IDLE, and Init_flag, CmpDirection, Step_en, busy and done SHALL be 0.
REQ-028 While reset=0, Win_idx, Step_cnt and the internal counters SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no done pulse.

Configuration
REQ-030 The macro ADDR_SEQ_BWD_EN SHALL select the backward pass.
REQ-031 With ADDR_SEQ_BWD_EN defined, each window SHALL run FWD then BWD as specified.
REQ-032 Without ADDR_SEQ_BWD_EN, BWD SHALL be absent, CmpDirection SHALL be constant 1, and remaining SHALL decrement at the end of FWD.

Structure
REQ-033 The FSM state encoding constants and the WIN_W default SHALL live in the shared include alongside `Data_Addr_width.
REQ-034 The block SHALL be a single module with no sub-module; its outputs drive the address-step stage directly.

Verification
REQ-035 The bench SHALL cover: segLen=8, winLen=4, hold=0 -> INIT, 4 FWD (Step_cnt 0..3), 4 BWD (3..0), INIT with Win_idx=1, repeat, then done; 19 busy cycles total.
REQ-036 The bench SHALL cover: segLen=10, winLen=4 -> windows of 4, 4, 2; the last BWD counts 1..0; Win_idx ends at 2.
REQ-037 The bench SHALL cover: segLen=0, start=1 -> DONE next cycle, done pulse, no Init_flag.
REQ-038 The bench SHALL cover: hold=1 for 3 cycles at FWD Step_cnt=2 -> Step_en=0 and Step_cnt=2 during the stall, then resume at 2 with no step lost.
REQ-039 The bench SHALL cover: reset low during BWD of window 1 -> all outputs 0 asynchronously, no done pulse; a subsequent start runs normally.
REQ-040 The bench SHALL cover: ADDR_SEQ_BWD_EN undefined, segLen=8, winLen=4 -> CmpDirection=1 always, 11 busy cycles.

Source files
------------

// File: rtl/addr_step_seq_pkg.sv
// Shared definitions for addr_step_seq: FSM state encoding, default window width
// and the fallback for the project-wide `Data_Addr_width macro.
`ifndef Data_Addr_width
`define Data_Addr_width 16
`endif

package addr_step_seq_pkg;

  localparam int WIN_W_DEFAULT = 7;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    FWD  = 3'd2,
    BWD  = 3'd3,
    DONE = 3'd4
  } state_e;

endpackage

// File: rtl/addr_step_seq.sv
// Window-by-window address-step sequencer for one parallel segment; all outputs registered.
// Define ADDR_SEQ_BWD_EN to add a backward pass after each forward pass.
`ifndef Data_Addr_width
`define Data_Addr_width 16
`endif

module addr_step_seq
  import addr_step_seq_pkg::*;
#(
  parameter int CNT_W = `Data_Addr_width,
  parameter int WIN_W = WIN_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] segLen,
  input  logic [WIN_W-1:0] winLen,
  input  logic             hold,
  output logic             Init_flag,
  output logic             CmpDirection,
  output logic             Step_en,
  output logic [CNT_W-1:0] Win_idx,
  output logic [WIN_W-1:0] Step_cnt,
  output logic             busy,
  output logic             done
);

  localparam int MW = (CNT_W > WIN_W) ? CNT_W : WIN_W;

  state_e           state_q;
  logic [CNT_W-1:0] rem_q;
  logic [WIN_W-1:0] win_len_q;
  logic [WIN_W-1:0] n_q;
  logic [CNT_W-1:0] win_q;
  logic [WIN_W-1:0] cnt_q;
  logic             init_q, dir_q, en_q, busy_q, done_q;

  logic [WIN_W-1:0] n_d;
  logic [WIN_W-1:0] n_last_d;
  logic [CNT_W-1:0] rem_d;

  // The last window of a segment may be shorter than the window length.
  function automatic logic [WIN_W-1:0] win_min(input logic [WIN_W-1:0] w,
                                              input logic [CNT_W-1:0] r);
    logic [MW-1:0] we;
    logic [MW-1:0] re;
    we = MW'(w);
    re = MW'(r);
    return (re < we) ? WIN_W'(re) : w;
  endfunction

  assign n_d      = win_min(win_len_q, rem_q);
  assign n_last_d = n_q - WIN_W'(1);
  assign rem_d    = rem_q - CNT_W'(n_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      win_len_q <= '0;
      n_q       <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      init_q    <= 1'b0;
      dir_q     <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          init_q <= 1'b0;
          en_q   <= 1'b0;
          dir_q  <= 1'b1;
          if (start) begin
            rem_q     <= segLen;
            win_len_q <= (winLen == '0) ? WIN_W'(1) : winLen;
            win_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            if (segLen == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= INIT;
              init_q  <= 1'b1;
            end
          end
        end
        INIT: begin
          n_q <= n_d;
          if (!hold) begin
            state_q <= FWD;
            init_q  <= 1'b0;
            en_q    <= 1'b1;
            cnt_q   <= '0;
          end
        end
        FWD: begin
          if (hold) begin
            en_q <= 1'b0;
          end else if (cnt_q != n_last_d) begin
            cnt_q <= cnt_q + WIN_W'(1);
            en_q  <= 1'b1;
          end else begin
`ifdef ADDR_SEQ_BWD_EN
            // Backward pass starts from the last forward index.
            state_q <= BWD;
            dir_q   <= 1'b0;
            en_q    <= 1'b1;
`else
            rem_q <= rem_d;
            en_q  <= 1'b0;
            cnt_q <= '0;
            if (rem_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= INIT;
              init_q  <= 1'b1;
              win_q   <= win_q + CNT_W'(1);
            end
`endif
          end
        end
`ifdef ADDR_SEQ_BWD_EN
        BWD: begin
          if (hold) begin
            en_q <= 1'b0;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIN_W'(1);
            en_q  <= 1'b1;
          end else begin
            rem_q <= rem_d;
            en_q  <= 1'b0;
            dir_q <= 1'b1;
            if (rem_d == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= INIT;
              init_q  <= 1'b1;
              win_q   <= win_q + CNT_W'(1);
            end
          end
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Init_flag    = init_q;
  assign CmpDirection = dir_q;
  assign Step_en      = en_q;
  assign Win_idx      = win_q;
  assign Step_cnt     = cnt_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_addr_step_seq.sv
// Scoreboard bench for addr_step_seq: a window-list reference model feeds expected
// per-cycle outputs; a negedge monitor pops and compares on every busy cycle.
module tb_addr_step_seq;

  localparam int CNT_W = 16;
  localparam int WIN_W = 7;
  localparam int K_INIT = 0;
  localparam int K_STEP = 1;
  localparam int K_DONE = 2;

`ifdef ADDR_SEQ_BWD_EN
  localparam bit BWD_ON = 1'b1;
`else
  localparam bit BWD_ON = 1'b0;
`endif

  typedef struct {
    int kind;
    bit dir;
    int cnt;
    int win;
  } item_t;

  typedef struct {
    bit init;
    bit dir;
    bit en;
    bit done;
    int win;
    int cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] segLen = '0;
  logic [WIN_W-1:0] winLen = '0;
  logic             hold = 1'b0;
  logic             Init_flag, CmpDirection, Step_en, busy, done;
  logic [CNT_W-1:0] Win_idx;
  logic [WIN_W-1:0] Step_cnt;

  int   n_tests = 0;
  int   n_fail = 0;
  int   bcount = 0;
  int   last_done_win = -1;
  exp_t exp_q[$];

  addr_step_seq #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .reset(reset), .start(start), .segLen(segLen), .winLen(winLen),
    .hold(hold), .Init_flag(Init_flag), .CmpDirection(CmpDirection), .Step_en(Step_en),
    .Win_idx(Win_idx), .Step_cnt(Step_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every cycle the DUT reports busy consumes one expected record.
  always @(negedge clk) begin
    exp_t e;
    if (reset && busy) begin
      bcount++;
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_busy: busy cycle %0d with no expected record", bcount);
      end else begin
        e = exp_q.pop_front();
        if (Init_flag !== e.init || CmpDirection !== e.dir || Step_en !== e.en ||
            done !== e.done || int'(Win_idx) != e.win || int'(Step_cnt) != e.cnt) begin
          n_fail++;
          $display("FAIL cycle%0d: got init=%0b dir=%0b en=%0b done=%0b win=%0d cnt=%0d, expected init=%0b dir=%0b en=%0b done=%0b win=%0d cnt=%0d",
                   bcount, Init_flag, CmpDirection, Step_en, done, Win_idx, Step_cnt,
                   e.init, e.dir, e.en, e.done, e.win, e.cnt);
        end
        if (done) last_done_win = int'(Win_idx);
      end
    end
  end

  // Reference model: list the windows of the segment, then replay it against a hold pattern.
  task automatic build_expect(input int seg, input int win, input int hmode, output bit hv[$]);
    item_t items[$];
    item_t it;
    exp_t  e;
    int    rem, w, wl, n, pos, k;
    bit    stalled, h;
    rem = seg;
    w   = 0;
    wl  = (win == 0) ? 1 : win;
    while (rem > 0) begin
      n = (wl < rem) ? wl : rem;
      items.push_back('{K_INIT, 1'b1, 0, w});
      for (int i = 0; i < n; i++) items.push_back('{K_STEP, 1'b1, i, w});
      if (BWD_ON) for (int i = n - 1; i >= 0; i--) items.push_back('{K_STEP, 1'b0, i, w});
      rem -= n;
      if (rem > 0) w++;
    end
    items.push_back('{K_DONE, 1'b1, 0, w});
    hv.delete();
    pos = 0;
    stalled = 1'b0;
    k = 0;
    while (pos < items.size()) begin
      it = items[pos];
      if (hmode == 1) h = ($urandom_range(0, 3) == 0);
      else if (hmode == 2) h = (k >= 3 && k <= 5);
      else h = 1'b0;
      e.init = (it.kind == K_INIT);
      e.dir  = it.dir;
      e.en   = (it.kind == K_STEP) && !stalled;
      e.done = (it.kind == K_DONE);
      e.win  = it.win;
      e.cnt  = it.cnt;
      exp_q.push_back(e);
      hv.push_back(h);
      if (h && it.kind != K_DONE) stalled = 1'b1;
      else begin
        pos++;
        stalled = 1'b0;
      end
      k++;
    end
  endtask

  // Called just after a rising edge with the DUT idle.
  task automatic run_seg(input int seg, input int win, input int hmode, input int abort_at);
    bit hv[$];
    exp_q.delete();
    build_expect(seg, win, hmode, hv);
    bcount = 0;
    last_done_win = -1;
    segLen = CNT_W'(seg);
    winLen = WIN_W'(win);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < hv.size(); k++) begin
      if (k == abort_at) begin
        hold = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("abort_async_outputs",
              {Init_flag, CmpDirection, Step_en, busy, done, (Win_idx != '0), (Step_cnt != '0)}, 0);
        exp_q.delete();
        for (int j = 0; j < 2; j++) begin
          @(negedge clk);
          check("abort_no_done", {done, busy}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end
      hold = hv[k];
      start = (hmode == 1) ? ($urandom_range(0, 7) == 0) : 1'b0;
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    check("idle_after_segment", {busy, done, Init_flag, Step_en}, 0);
    check("expected_all_consumed", exp_q.size(), 0);
    check("busy_cycle_count", bcount, hv.size());
    @(posedge clk); #1;
  endtask

  initial begin
    int seg, win;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          {Init_flag, CmpDirection, Step_en, busy, done, (Win_idx != '0), (Step_cnt != '0)}, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle_after_reset", {busy, done, Init_flag, Step_en}, 0);

    run_seg(8, 4, 0, -1);
    check("seg8_win4_busy", bcount, BWD_ON ? 19 : 11);
    check("seg8_win4_last_win", last_done_win, 1);

    run_seg(10, 4, 0, -1);
    check("seg10_win4_last_win", last_done_win, 2);

    run_seg(0, 5, 0, -1);
    check("seg0_busy", bcount, 1);

    run_seg(8, 4, 2, -1);
    check("hold_stall_busy", bcount, BWD_ON ? 22 : 14);

    run_seg(8, 4, 0, BWD_ON ? 15 : 7);
    run_seg(8, 4, 0, -1);
    check("after_abort_busy", bcount, BWD_ON ? 19 : 11);

    run_seg(3, 0, 0, -1);
    check("winlen0_last_win", last_done_win, 2);

    for (int r = 0; r < 25; r++) begin
      seg = $urandom_range(0, 20);
      win = $urandom_range(0, 7);
      run_seg(seg, win, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
